data_pipe_path_arbiter: RTL and testbench

- Round-robin path scheduler for the 8:1 data pipe interconnect.
- Watches per-source valid requests and picks a winner. Drives the interconnect's `sw`/`vld_sw` so that exactly one upstream owns m00 at a time.
- Releases ownership on packet end, beat quota or requester idle timeout. Switches only after the pipe has drained, so no beat is lost or mis-routed.

---
 rtl/data_pipe_path_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_data_pipe_path_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_pipe_path_arbiter.sv
// ---------------------------------------------------------------------------
// data_pipe_path_arbiter
//
// Round-robin path scheduler for the 8:1 data pipe interconnect. Picks one
// requesting source, steers the interconnect to it (sw), waits for the path
// to settle, then enables it (vld_sw). Ownership ends on packet end, beat
// quota or requester idle timeout. The next owner is picked only after the
// pipe has drained.
//
// Optional feature macro: DATA_PIPE_ARB_PRIO0_EN
//   When defined, source 0 has strict priority and a grant to source 0
//   leaves the round-robin pointer untouched.
//
// Ports:
//   clock     in   system clock
//   rst       in   synchronous reset, active-high
//   clk_en    in   clock enable; all state advances only when high
//   req       in   per-source valid requests [NUM]
//   xfer      in   downstream beat accepted
//   pkt_last  in   last beat of packet (qualified by xfer)
//   pipe_idle in   interconnect connector and buffer are empty
//   sw        out  selected path index [SW_W]
//   vld_sw    out  path enable, high only while granted
//   grant     out  one-hot owner, registered [NUM]
//   busy      out  high whenever not idle
// ---------------------------------------------------------------------------
module data_pipe_path_arbiter #(
  parameter int NUM       = 8,
  parameter int SW_W      = 3,
  parameter int MAX_BEATS = 16,
  parameter int IDLE_TO   = 8,
  parameter int SETTLE    = 2
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            clk_en,
  input  logic [NUM-1:0]  req,
  input  logic            xfer,
  input  logic            pkt_last,
  input  logic            pipe_idle,
  output logic [SW_W-1:0] sw,
  output logic            vld_sw,
  output logic [NUM-1:0]  grant,
  output logic            busy
);

  localparam int BEAT_W   = (MAX_BEATS < 1) ? 1 : $clog2(MAX_BEATS + 1);
  localparam int IDLE_W   = $clog2(IDLE_TO + 1);
  localparam int SETTLE_W = $clog2(SETTLE + 1);

  localparam logic [BEAT_W-1:0]   BEAT_MAX    = BEAT_W'(MAX_BEATS);
  localparam logic [IDLE_W-1:0]   IDLE_LAST   = IDLE_W'(IDLE_TO - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SWITCH, ST_GRANT, ST_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [SW_W-1:0]     sw_q, sw_d;
  logic                vld_sw_q, vld_sw_d;
  logic [NUM-1:0]      grant_q, grant_d;
  logic [SW_W-1:0]     ptr_q, ptr_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;

  // Candidate source at each offset from the pointer, modulo NUM.
  logic [SW_W-1:0] cand_idx [NUM];
  logic [SW_W-1:0] win_idx;
  logic [NUM-1:0]  win_onehot;

  for (genvar gi = 0; gi < NUM; gi++) begin : g_cand
    logic [SW_W:0] sum;
    assign sum = {1'b0, ptr_q} + (SW_W+1)'(gi);
    assign cand_idx[gi] = (sum >= (SW_W+1)'(NUM)) ? SW_W'(sum - (SW_W+1)'(NUM))
                                                  : SW_W'(sum);
    assign win_onehot[gi] = (win_idx == SW_W'(gi));
  end

  // Scan from the farthest offset down so the closest requester wins last.
  always_comb begin
    win_idx = ptr_q;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (req[cand_idx[i]]) win_idx = cand_idx[i];
    end
`ifdef DATA_PIPE_ARB_PRIO0_EN
    if (req[0]) win_idx = '0;
`endif
  end

  logic            owner_active;
  logic            beat_hit;
  logic            idle_hit;
  logic            release_now;
  logic [SW_W-1:0] ptr_inc;

  always_comb begin
    state_d  = state_q;
    sw_d     = sw_q;
    vld_sw_d = vld_sw_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    settle_d = settle_q;
    beat_d   = beat_q;
    idle_d   = idle_q;

    owner_active = req[sw_q] | xfer;
    beat_hit     = 1'b0;
    idle_hit     = 1'b0;
    release_now  = 1'b0;
    ptr_inc      = (sw_q == SW_W'(NUM - 1)) ? '0 : sw_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d  = ST_SWITCH;
          sw_d     = win_idx;
          grant_d  = win_onehot;
          settle_d = '0;
          beat_d   = '0;
          idle_d   = '0;
        end
      end
      ST_SWITCH: begin
        beat_d = '0;
        idle_d = '0;
        if (settle_q == SETTLE_LAST) begin
          state_d  = ST_GRANT;
          vld_sw_d = 1'b1;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_GRANT: begin
        if (xfer && (MAX_BEATS != 0)) begin
          if (beat_q != BEAT_MAX) beat_d = beat_q + 1'b1;
          beat_hit = (BEAT_W'(beat_q + 1'b1) == BEAT_MAX);
        end
        if (owner_active) begin
          idle_d = '0;
        end else begin
          if (idle_q != IDLE_W'(IDLE_TO)) idle_d = idle_q + 1'b1;
          idle_hit = (idle_q == IDLE_LAST);
        end
        release_now = (xfer & pkt_last) | beat_hit | idle_hit;
        if (release_now) begin
          state_d  = ST_DRAIN;
          vld_sw_d = 1'b0;
`ifdef DATA_PIPE_ARB_PRIO0_EN
          if (sw_q != '0) ptr_d = ptr_inc;
`else
          ptr_d = ptr_inc;
`endif
        end
      end
      ST_DRAIN: begin
        vld_sw_d = 1'b0;
        if (pipe_idle) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sw_q     <= '0;
      vld_sw_q <= 1'b0;
      grant_q  <= '0;
      ptr_q    <= '0;
      settle_q <= '0;
      beat_q   <= '0;
      idle_q   <= '0;
    end else if (clk_en) begin
      state_q  <= state_d;
      sw_q     <= sw_d;
      vld_sw_q <= vld_sw_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      settle_q <= settle_d;
      beat_q   <= beat_d;
      idle_q   <= idle_d;
    end
  end

  assign sw     = sw_q;
  assign vld_sw = vld_sw_q;
  assign grant  = grant_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_data_pipe_path_arbiter.sv
module tb_data_pipe_path_arbiter;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b1;
  logic [7:0] req = 8'h00;
  logic       xfer = 1'b0;
  logic       pkt_last = 1'b0;
  logic       pipe_idle = 1'b1;
  logic [2:0] sw;
  logic       vld_sw;
  logic [7:0] grant;
  logic       busy;

  int total = 0;
  int bad = 0;
  int exp_q[$];

  data_pipe_path_arbiter dut (
    .clock(clock), .rst(rst), .clk_en(clk_en), .req(req), .xfer(xfer),
    .pkt_last(pkt_last), .pipe_idle(pipe_idle), .sw(sw), .vld_sw(vld_sw),
    .grant(grant), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_vld(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (vld_sw === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic do_release();
    xfer = 1'b1;
    pkt_last = 1'b1;
    tick();
    xfer = 1'b0;
    pkt_last = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({sw, vld_sw, grant, busy} !== 13'h0) begin
      bad++;
      $display("FAIL reset_state: got sw=%0d vld=%b grant=%h busy=%b want all zero", sw, vld_sw, grant, busy);
    end
  endtask

  task automatic test_single_packet();
    int e;
    logic [7:0] g_hold;
    exp_q.push_back(0);
    req = 8'h01;
    tick();
    e = exp_q.pop_front();
    total++;
    if (grant !== (8'h01 << e) || sw !== 3'(e) || busy !== 1'b1 || vld_sw !== 1'b0) begin
      bad++;
      $display("FAIL single_switch: got sw=%0d grant=%h busy=%b vld=%b want sw=%0d grant=%h busy=1 vld=0", sw, grant, busy, vld_sw, e, 8'h01 << e);
    end else $display("grant src=%0d sw=%0d", e, sw);
    g_hold = grant;
    clk_en = 1'b0;
    tick(); tick(); tick();
    total++;
    if (vld_sw !== 1'b0 || grant !== g_hold) begin
      bad++;
      $display("FAIL clk_en_freeze: got vld=%b grant=%h want vld=0 grant=%h", vld_sw, grant, g_hold);
    end
    clk_en = 1'b1;
    tick();
    total++;
    if (vld_sw !== 1'b0) begin
      bad++;
      $display("FAIL settle_early: got vld=%b want 0", vld_sw);
    end
    tick();
    total++;
    if (vld_sw !== 1'b1) begin
      bad++;
      $display("FAIL settle_done: got vld=%b want 1", vld_sw);
    end
    xfer = 1'b1;
    tick(); tick();
    total++;
    if (vld_sw !== 1'b1) begin
      bad++;
      $display("FAIL mid_packet: got vld=%b want 1", vld_sw);
    end
    pkt_last = 1'b1;
    tick();
    total++;
    if (vld_sw !== 1'b0 || busy !== 1'b1 || grant !== 8'h01 || sw !== 3'd0) begin
      bad++;
      $display("FAIL pkt_end: got vld=%b busy=%b grant=%h sw=%0d want vld=0 busy=1 grant=01 sw=0", vld_sw, busy, grant, sw);
    end
    xfer = 1'b0; pkt_last = 1'b0; req = 8'h00; pipe_idle = 1'b0;
    tick(); tick();
    total++;
    if (busy !== 1'b1 || grant !== 8'h01) begin
      bad++;
      $display("FAIL drain_hold: got busy=%b grant=%h want busy=1 grant=01", busy, grant);
    end
    pipe_idle = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0 || grant !== 8'h00 || sw !== 3'd0) begin
      bad++;
      $display("FAIL drain_exit: got busy=%b grant=%h sw=%0d want busy=0 grant=00 sw=0", busy, grant, sw);
    end
  endtask

  task automatic test_round_robin();
    int e;
    bit ok;
    do_reset();
    for (int i = 0; i < 9; i++) exp_q.push_back(i % 8);
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      wait_vld(ok);
      e = exp_q.pop_front();
      total++;
      if (!ok || grant !== (8'h01 << e) || sw !== 3'(e)) begin
        bad++;
        $display("FAIL rr_order[%0d]: got grant=%h sw=%0d ok=%b want grant=%h sw=%0d", i, grant, sw, ok, 8'h01 << e, e);
      end else $display("grant src=%0d sw=%0d", e, sw);
      do_release();
    end
    req = 8'h00;
    tick(); tick();
  endtask

  task automatic test_beat_quota();
    int e;
    int n;
    bit ok;
    exp_q.push_back(2);
    exp_q.push_back(2);
    req = 8'h04;
    wait_vld(ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || grant !== (8'h01 << e)) begin
      bad++;
      $display("FAIL quota_grant: got grant=%h ok=%b want %h", grant, ok, 8'h01 << e);
    end else $display("grant src=%0d sw=%0d", e, sw);
    xfer = 1'b1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      n++;
      if (vld_sw !== 1'b1) break;
    end
    xfer = 1'b0;
    total++;
    if (n !== 16) begin
      bad++;
      $display("FAIL quota_beats: got %0d beats want 16", n);
    end else $display("quota release after %0d beats", n);
    wait_vld(ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || grant !== (8'h01 << e)) begin
      bad++;
      $display("FAIL quota_regrant: got grant=%h ok=%b want %h", grant, ok, 8'h01 << e);
    end else $display("grant src=%0d sw=%0d", e, sw);
    do_release();
    req = 8'h00;
    tick(); tick();
  endtask

  task automatic test_idle_timeout();
    int e;
    bit ok;
    exp_q.push_back(3);
    req = 8'h08;
    wait_vld(ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || grant !== (8'h01 << e)) begin
      bad++;
      $display("FAIL idle_grant: got grant=%h ok=%b want %h", grant, ok, 8'h01 << e);
    end else $display("grant src=%0d sw=%0d", e, sw);
    req = 8'h00;
    for (int k = 0; k < 7; k++) tick();
    total++;
    if (vld_sw !== 1'b1) begin
      bad++;
      $display("FAIL idle_early: got vld=%b after 7 idle cycles want 1", vld_sw);
    end
    tick();
    total++;
    if (vld_sw !== 1'b0) begin
      bad++;
      $display("FAIL idle_release: got vld=%b after 8 idle cycles want 0", vld_sw);
    end else $display("idle release after 8 cycles");
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_done: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid_grant();
    int e;
    bit ok;
    exp_q.push_back(5);
    req = 8'h20;
    wait_vld(ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || grant !== (8'h01 << e) || sw !== 3'(e)) begin
      bad++;
      $display("FAIL rst_pre_grant: got grant=%h sw=%0d ok=%b want grant=%h", grant, sw, ok, 8'h01 << e);
    end else $display("grant src=%0d sw=%0d", e, sw);
    pipe_idle = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (sw !== 3'd0 || vld_sw !== 1'b0 || grant !== 8'h00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_abort: got sw=%0d vld=%b grant=%h busy=%b want all zero", sw, vld_sw, grant, busy);
    end
    exp_q.push_back(5);
    tick();
    e = exp_q.pop_front();
    total++;
    if (grant !== (8'h01 << e) || sw !== 3'(e) || vld_sw !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_regrant: got grant=%h sw=%0d vld=%b busy=%b want grant=%h sw=%0d vld=0 busy=1", grant, sw, vld_sw, busy, 8'h01 << e, e);
    end else $display("grant src=%0d sw=%0d", e, sw);
    wait_vld(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rst_regrant_vld: got no vld_sw within budget want vld=1");
    end
    pipe_idle = 1'b1;
    do_release();
    req = 8'h00;
    tick(); tick();
  endtask

  task automatic test_pointer_prio();
    int e;
    bit ok;
    do_reset();
    exp_q.push_back(6);
`ifdef DATA_PIPE_ARB_PRIO0_EN
    exp_q.push_back(0);
    exp_q.push_back(7);
`else
    exp_q.push_back(7);
    exp_q.push_back(0);
`endif
    req = 8'h40;
    for (int i = 0; i < 3; i++) begin
      wait_vld(ok);
      e = exp_q.pop_front();
      total++;
      if (!ok || grant !== (8'h01 << e) || sw !== 3'(e)) begin
        bad++;
        $display("FAIL ptr_order[%0d]: got grant=%h sw=%0d ok=%b want grant=%h", i, grant, sw, ok, 8'h01 << e);
      end else $display("grant src=%0d sw=%0d", e, sw);
      do_release();
`ifdef DATA_PIPE_ARB_PRIO0_EN
      req = (i == 0) ? 8'h81 : 8'h80;
`else
      req = 8'h81;
`endif
      if (i == 0) begin
        req = 8'h00;
        tick();
`ifdef DATA_PIPE_ARB_PRIO0_EN
        req = 8'h81;
`else
        req = 8'h81;
`endif
      end
    end
    req = 8'h00;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_beat_quota();
    test_idle_timeout();
    test_reset_mid_grant();
    test_pointer_prio();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
